brew_sequencer: RTL and testbench

BREW_SEQUENCER -- requirements
Module: brew_sequencer

---
 rtl/coffee_pkg.sv | 29 ++
 rtl/stage_timer.sv | 16 +
 rtl/brew_sequencer.sv | 93 +++++++++
 tb/tb_brew_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/coffee_pkg.sv
// coffee_pkg: shared state codes, drink selections, output bundle and default stage lengths
package coffee_pkg;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GRIND    = 3'd1,
    S_HEAT     = 3'd2,
    S_BREW     = 3'd3,
    S_DISPENSE = 3'd4,
    S_FINISH   = 3'd5,
    S_FAULT    = 3'd6
  } state_t;
  localparam logic [1:0] SEL_ESPRESSO = 2'b00;
  localparam logic [1:0] SEL_LONG     = 2'b01;
  localparam logic [1:0] SEL_WATER    = 2'b10;
  localparam logic [1:0] SEL_RSVD     = 2'b11;
  localparam int unsigned DEF_GRIND_CYC = 3000000;
  localparam int unsigned DEF_HEAT_CYC  = 5000000;
  localparam int unsigned DEF_BREW_CYC  = 4000000;
  localparam int unsigned DEF_DISP_CYC  = 2000000;
  typedef struct packed {
    logic grinder;
    logic heater;
    logic pump;
    logic valve;
    logic busy;
    logic done;
    logic fault;
  } outs_t;
endpackage

// File: rtl/stage_timer.sv
// stage_timer: down-counter that flags the last cycle of a stage; zero length behaves as one
module stage_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] length,
  output logic        expired
);
  logic [31:0] cnt;
  // load on stage entry, then count down to 1 and hold there
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= (length == '0) ? 32'd1 : length;
    else if (cnt > 32'd1) cnt <= cnt - 32'd1;
  assign expired = (cnt == 32'd1);
endmodule

// File: rtl/brew_sequencer.sv
// brew_sequencer: coffee machine stage sequencer with registered actuator enables
module brew_sequencer
  import coffee_pkg::*;
#(
  parameter int unsigned GRIND_CYC = DEF_GRIND_CYC,
  parameter int unsigned HEAT_CYC  = DEF_HEAT_CYC,
  parameter int unsigned BREW_CYC  = DEF_BREW_CYC,
  parameter int unsigned DISP_CYC  = DEF_DISP_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] drink_sel,
  input  logic       water_ok,
  input  logic       cancel,
  input  logic       fault_ack,
  output logic       grinder_en,
  output logic       heater_en,
  output logic       pump_en,
  output logic       valve_en,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [2:0] state_o
);
  state_t      state, next;
  logic [1:0]  sel;
  logic        armed;
  logic        load, expired;
  logic [31:0] length;
  outs_t       outs_d, outs_q;
  stage_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .length (length),
    .expired(expired)
  );
  // state, latched selection, start re-arm and output registers
  always_ff @(posedge clk)
    if (reset) begin
      state  <= S_IDLE;
      sel    <= SEL_ESPRESSO;
      armed  <= 1'b1;
      outs_q <= '0;
    end else begin
      state  <= next;
      outs_q <= outs_d;
      if (state == S_IDLE && next != S_IDLE) sel <= drink_sel;
      armed  <= !start ? 1'b1 : (state == S_FINISH) ? 1'b0 : armed;
    end
  // next-state: water loss beats cancel, cancel beats stage expiry
  always_comb begin
    next = state;
    case (state)
      S_IDLE:     if (start && armed)
                    next = (!water_ok || drink_sel == SEL_RSVD) ? S_FAULT :
                           (drink_sel == SEL_WATER) ? S_HEAT : S_GRIND;
      S_GRIND:    next = cancel ? S_IDLE : expired ? S_HEAT : S_GRIND;
      S_HEAT:     next = !water_ok ? S_FAULT : cancel ? S_IDLE :
                         expired ? ((sel == SEL_WATER) ? S_DISPENSE : S_BREW) : S_HEAT;
      S_BREW:     next = !water_ok ? S_FAULT : cancel ? S_IDLE : expired ? S_DISPENSE : S_BREW;
      S_DISPENSE: next = !water_ok ? S_FAULT : cancel ? S_IDLE : expired ? S_FINISH : S_DISPENSE;
      S_FINISH:   next = S_IDLE;
      S_FAULT:    next = (fault_ack && water_ok) ? S_IDLE : S_FAULT;
      default:    next = S_IDLE;
    endcase
  end
  // outputs and timer reload derived from the state being entered
  always_comb begin
    load           = (next != state);
    length         = (next == S_GRIND) ? 32'(GRIND_CYC) :
                     (next == S_HEAT)  ? 32'(HEAT_CYC)  :
                     (next == S_BREW)  ? ((sel == SEL_LONG) ? 32'(BREW_CYC) << 1 : 32'(BREW_CYC)) :
                     (next == S_DISPENSE) ? 32'(DISP_CYC) : 32'd1;
    outs_d         = '0;
    outs_d.grinder = (next == S_GRIND);
    outs_d.heater  = (next == S_HEAT) || (next == S_BREW);
    outs_d.pump    = (next == S_BREW);
    outs_d.valve   = (next == S_DISPENSE);
    outs_d.busy    = (next != S_IDLE);
    outs_d.done    = (next == S_FINISH);
    outs_d.fault   = (next == S_FAULT);
  end
  assign grinder_en = outs_q.grinder;
  assign heater_en  = outs_q.heater;
  assign pump_en    = outs_q.pump;
  assign valve_en   = outs_q.valve;
  assign busy       = outs_q.busy;
  assign done       = outs_q.done;
  assign fault      = outs_q.fault;
  assign state_o    = state;
endmodule

// File: tb/tb_brew_sequencer.sv
// tb_brew_sequencer: directed checks of stage lengths, cancel, fault and reset behaviour
module tb_brew_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] drink_sel = 2'b00;
  logic       water_ok = 1'b1;
  logic       cancel = 1'b0;
  logic       fault_ack = 1'b0;
  logic       grinder_en, heater_en, pump_en, valve_en, busy, done, fault;
  logic [2:0] state_o;
  int         tests = 0;
  int         fails = 0;
  logic       clr = 1'b1;
  int         cg, ch, cp, cv, cb, cd;
  brew_sequencer #(.GRIND_CYC(4), .HEAT_CYC(6), .BREW_CYC(8), .DISP_CYC(3)) dut (
    .clk(clk), .reset(reset), .start(start), .drink_sel(drink_sel), .water_ok(water_ok),
    .cancel(cancel), .fault_ack(fault_ack), .grinder_en(grinder_en), .heater_en(heater_en),
    .pump_en(pump_en), .valve_en(valve_en), .busy(busy), .done(done), .fault(fault),
    .state_o(state_o)
  );
  always #5 clk = ~clk;
  // per-output high-cycle counters sampled on the falling edge
  always @(negedge clk)
    if (clr) begin
      cg <= 0; ch <= 0; cp <= 0; cv <= 0; cb <= 0; cd <= 0;
    end else begin
      cg <= cg + int'(grinder_en);
      ch <= ch + int'(heater_en);
      cp <= cp + int'(pump_en);
      cv <= cv + int'(valve_en);
      cb <= cb + int'(busy);
      cd <= cd + int'(done);
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic clear_counts();
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask
  task automatic run_drink(input logic [1:0] s);
    clear_counts();
    drink_sel = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("first_state", 32'(state_o), (s == 2'b10) ? 32'd2 : 32'd1);
    for (int i = 0; i < 200 && busy; i++) tick();
    chk("drink_timeout", 32'(busy), 32'd0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_outs", {25'd0, grinder_en, heater_en, pump_en, valve_en, busy, done, fault}, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    // espresso
    run_drink(2'b00);
    chk("esp_grind", cg, 4);
    chk("esp_heat", ch, 14);
    chk("esp_pump", cp, 8);
    chk("esp_valve", cv, 3);
    chk("esp_busy", cb, 22);
    chk("esp_done", cd, 1);
    // long
    run_drink(2'b01);
    chk("long_pump", cp, 16);
    chk("long_heat", ch, 22);
    chk("long_busy", cb, 30);
    // hot water
    run_drink(2'b10);
    chk("hw_grind", cg, 0);
    chk("hw_pump", cp, 0);
    chk("hw_heat", ch, 6);
    chk("hw_valve", cv, 3);
    chk("hw_done", cd, 1);
    // water loss in BREW cycle 3
    drink_sel = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("wl_in_brew", 32'(state_o), 32'd3);
    water_ok = 1'b0;
    tick();
    chk("wl_fault", 32'(fault), 32'd1);
    chk("wl_state", 32'(state_o), 32'd6);
    chk("wl_enables", {28'd0, grinder_en, heater_en, pump_en, valve_en}, 32'd0);
    fault_ack = 1'b1;
    tick();
    chk("wl_hold", 32'(state_o), 32'd6);
    water_ok = 1'b1;
    tick();
    fault_ack = 1'b0;
    chk("wl_exit", 32'(state_o), 32'd0);
    chk("wl_fault_clr", 32'(fault), 32'd0);
    // cancel plus water loss in HEAT
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("cw_in_heat", 32'(state_o), 32'd2);
    cancel = 1'b1;
    water_ok = 1'b0;
    tick();
    cancel = 1'b0;
    water_ok = 1'b1;
    chk("cw_fault_wins", 32'(state_o), 32'd6);
    fault_ack = 1'b1;
    tick();
    fault_ack = 1'b0;
    // cancel alone in GRIND cycle 2
    clear_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("cn_in_grind", 32'(state_o), 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cn_idle", 32'(state_o), 32'd0);
    chk("cn_grinder", 32'(grinder_en), 32'd0);
    tick();
    chk("cn_no_done", cd, 0);
    // reserved selection and dry tank at start
    drink_sel = 2'b11;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rsvd_fault", 32'(state_o), 32'd6);
    fault_ack = 1'b1;
    tick();
    fault_ack = 1'b0;
    drink_sel = 2'b00;
    water_ok = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    water_ok = 1'b1;
    chk("dry_fault", 32'(fault), 32'd1);
    fault_ack = 1'b1;
    tick();
    fault_ack = 1'b0;
    // reset in DISPENSE cycle 1
    clear_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (18) tick();
    chk("rs_in_disp", 32'(valve_en), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_state", 32'(state_o), 32'd0);
    chk("rs_outs", {25'd0, grinder_en, heater_en, pump_en, valve_en, busy, done, fault}, 32'd0);
    tick();
    chk("rs_no_done", cd, 0);
    // start held high through FINISH
    start = 1'b1;
    tick();
    repeat (21) tick();
    chk("hold_finish", 32'(done), 32'd1);
    tick();
    chk("hold_idle", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("hold_no_retrig", 32'(busy), 32'd0);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rearm_start", 32'(busy), 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("rearm_cancel", 32'(busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
